// File: rtl/stim_chk_pkg.sv
// Shared constants and helpers for the stimulus/response checker:
// FSM state encodings, Galois LFSR mask, default seed and the seed/step functions.
package stim_chk_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_RST_HOLD = 2'd1;
    localparam state_t ST_RUN      = 2'd2;
    localparam state_t ST_DONE     = 2'd3;

    localparam logic [31:0] LFSR_MASK    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [31:0] fix_seed(input logic [31:0] s);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'd0);
    endfunction

endpackage

// File: rtl/stim_lfsr32.sv
// 32-bit right-shifting Galois LFSR with synchronous seed load and advance.
module stim_lfsr32
    import stim_chk_pkg::*;
#(
    parameter logic [31:0] RESET_SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] q
);

    logic [31:0] q_q;
    logic [31:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (advance) begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RESET_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/stim_resp_checker.sv
// On-chip stimulus/response checker comparing a golden and a DUT instance.
// Define STIM_CHK_FIRST_FAIL_CAPTURE_EN to latch index and buses of the first mismatch.
module stim_resp_checker
    import stim_chk_pkg::*;
#(
    parameter int          NUM_VECTORS = 1000,
    parameter int          SETTLE      = 2,
    parameter int          RST_CYCLES  = 2,
    parameter int          CNT_W       = 16,
    parameter logic [31:0] SEED        = 32'hACE1_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      golden_in,
    input  logic [31:0]      dut_in,
    output logic [31:0]      stim_out,
    output logic             dut_rst,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [15:0]      first_fail_idx,
    output logic [31:0]      first_fail_golden,
    output logic [31:0]      first_fail_dut
);

    localparam logic [31:0]      SEED_FIX = fix_seed(SEED);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            state_q, state_d;
    logic [31:0]       hold_q, hold_d;
    logic [31:0]       vec_q, vec_d;
    logic [31:0]       stim_q, stim_d;
    logic              dut_rst_q, dut_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lfsr_load;
    logic              lfsr_adv;
    logic [31:0]       lfsr_q;
    logic              mismatch;
    logic              settle_end;

    // X/Z on either bus must count as a mismatch in simulation.
    assign mismatch   = (golden_in !== dut_in);
    assign settle_end = (hold_q == 32'(SETTLE - 1));

    stim_lfsr32 #(
        .RESET_SEED(SEED_FIX)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (lfsr_load),
        .seed   (SEED_FIX),
        .advance(lfsr_adv),
        .q      (lfsr_q)
    );

    // The LFSR always holds the next vector to apply, so applying a vector also advances it.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        vec_d     = vec_q;
        stim_d    = stim_q;
        dut_rst_d = dut_rst_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        cnt_d     = cnt_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        if (abort) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            dut_rst_d = 1'b1;
            stim_d    = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d   = ST_RST_HOLD;
                        hold_d    = 32'd0;
                        vec_d     = 32'd0;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        pass_d    = 1'b0;
                        cnt_d     = '0;
                        dut_rst_d = 1'b1;
                        stim_d    = 32'd0;
                        lfsr_load = 1'b1;
                    end
                end
                ST_RST_HOLD: begin
                    if (hold_q == 32'(RST_CYCLES)) begin
                        state_d   = ST_RUN;
                        hold_d    = 32'd0;
                        dut_rst_d = 1'b0;
                        stim_d    = lfsr_q;
                        lfsr_adv  = 1'b1;
                    end else begin
                        hold_d = hold_q + 32'd1;
                    end
                end
                ST_RUN: begin
                    if (settle_end) begin
                        hold_d = 32'd0;
                        if (mismatch && (cnt_q != CNT_MAX)) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (vec_q == 32'(NUM_VECTORS - 1)) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (cnt_q == '0) && !mismatch;
                        end else begin
                            vec_d    = vec_q + 32'd1;
                            stim_d   = lfsr_q;
                            lfsr_adv = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 32'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hold_q    <= 32'd0;
            vec_q     <= 32'd0;
            stim_q    <= 32'd0;
            dut_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            vec_q     <= vec_d;
            stim_q    <= stim_d;
            dut_rst_q <= dut_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            cnt_q     <= cnt_d;
        end
    end

    assign stim_out     = stim_q;
    assign dut_rst      = dut_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign mismatch_cnt = cnt_q;

`ifdef STIM_CHK_FIRST_FAIL_CAPTURE_EN
    logic [15:0] ff_idx_q;
    logic [31:0] ff_golden_q;
    logic [31:0] ff_dut_q;
    logic        ff_fire;

    // A zero count at a mismatching compare means this is the run's first failure.
    assign ff_fire = !abort && (state_q == ST_RUN) && settle_end && mismatch && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_idx_q    <= 16'd0;
            ff_golden_q <= 32'd0;
            ff_dut_q    <= 32'd0;
        end else if (lfsr_load) begin
            ff_idx_q    <= 16'd0;
            ff_golden_q <= 32'd0;
            ff_dut_q    <= 32'd0;
        end else if (ff_fire) begin
            ff_idx_q    <= vec_q[15:0];
            ff_golden_q <= golden_in;
            ff_dut_q    <= dut_in;
        end
    end

    assign first_fail_idx    = ff_idx_q;
    assign first_fail_golden = ff_golden_q;
    assign first_fail_dut    = ff_dut_q;
`else
    assign first_fail_idx    = 16'd0;
    assign first_fail_golden = 32'd0;
    assign first_fail_dut    = 32'd0;
`endif

endmodule

// File: tb/tb_stim_resp_checker.sv
// Self-checking bench: timeline-based reference model of the checker compared every cycle,
// plus literal expectations for run length, saturation, abort, async reset and seed handling.
module tb_stim_resp_checker;

    localparam int N    = 20;
    localparam int S    = 3;
    localparam int R    = 2;
    localparam int CMAX = 15;
    localparam int DONE_EDGE = 1 + R + N * S;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] golden_in;
    logic [31:0] dut_in;
    logic [31:0] stim_out;
    logic        dut_rst, busy, done, pass;
    logic [3:0]  mismatch_cnt;
    logic [15:0] ff_idx;
    logic [31:0] ff_golden, ff_dut;

    logic        start_d = 1'b0;
    logic [31:0] stim_d;
    logic        dut_rst_d, busy_d, done_d, pass_d;
    logic [15:0] cnt_d;
    logic [15:0] ff_idx_d;
    logic [31:0] ff_golden_d, ff_dut_d;

    int          n_checks = 0;
    int          n_pass = 0;
    int          mode = 0;
    logic [31:0] key = 32'd0;
    logic        cmp_en = 1'b0;
    logic [31:0] vec [N];

    always #5 clk = ~clk;

    stim_resp_checker #(
        .NUM_VECTORS(N), .SETTLE(S), .RST_CYCLES(R), .CNT_W(4), .SEED(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .golden_in(golden_in), .dut_in(dut_in), .stim_out(stim_out),
        .dut_rst(dut_rst), .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .first_fail_idx(ff_idx),
        .first_fail_golden(ff_golden), .first_fail_dut(ff_dut)
    );

    stim_resp_checker dut_def (
        .clk(clk), .rst(rst), .start(start_d), .abort(1'b0),
        .golden_in(stim_d), .dut_in(stim_d), .stim_out(stim_d),
        .dut_rst(dut_rst_d), .busy(busy_d), .done(done_d), .pass(pass_d),
        .mismatch_cnt(cnt_d), .first_fail_idx(ff_idx_d),
        .first_fail_golden(ff_golden_d), .first_fail_dut(ff_dut_d)
    );

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Golden instance echoes the stimulus; the DUT instance corrupts it according to mode.
    always_comb begin
        golden_in = stim_out;
        dut_in    = golden_in;
        case (mode)
            1: dut_in = golden_in ^ ((stim_out == vec[5]) ? 32'd1 : 32'd0);
            2: dut_in = 32'd0;
            3: dut_in = (((stim_out ^ key) & 32'h3) == 32'd0) ? (golden_in ^ (key | 32'd1)) : golden_in;
            default: dut_in = golden_in;
        endcase
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: position within a run is tracked as edges since the accepted start.
    int          m_t = 0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_pass = 1'b0, m_dut_rst = 1'b1;
    logic [31:0] m_stim = 32'd0;
    int          m_cnt = 0;
    logic [31:0] m_ff_idx = 32'd0, m_ff_g = 32'd0, m_ff_d = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0; m_busy = 0; m_done = 0; m_pass = 0; m_dut_rst = 1; m_stim = 0;
            m_cnt = 0; m_ff_idx = 0; m_ff_g = 0; m_ff_d = 0;
        end else if (abort) begin
            m_busy = 0; m_done = 0; m_pass = 0; m_dut_rst = 1; m_stim = 0;
        end else if (start && !m_busy) begin
            m_t = 0; m_busy = 1; m_done = 0; m_pass = 0; m_dut_rst = 1; m_stim = 0;
            m_cnt = 0; m_ff_idx = 0; m_ff_g = 0; m_ff_d = 0;
        end else if (m_busy) begin
            m_t++;
            if (m_t > R + 1 && ((m_t - R - 1) % S) == 0 && golden_in !== dut_in) begin
                if (m_cnt == 0) begin
                    m_ff_idx = 32'((m_t - R - 1) / S - 1);
                    m_ff_g = golden_in;
                    m_ff_d = dut_in;
                end
                if (m_cnt < CMAX) m_cnt++;
            end
            if (m_t <= R) begin
                m_dut_rst = 1; m_stim = 0;
            end else if (m_t < DONE_EDGE) begin
                m_dut_rst = 0; m_stim = vec[(m_t - R - 1) / S];
            end else begin
                m_busy = 0; m_done = 1; m_pass = (m_cnt == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            check_output("stim_out", stim_out, m_stim);
            check_output("busy", 32'(busy), 32'(m_busy));
            check_output("done", 32'(done), 32'(m_done));
            check_output("pass", 32'(pass), 32'(m_pass));
            check_output("mismatch_cnt", 32'(mismatch_cnt), 32'(m_cnt));
            if (!m_done) check_output("dut_rst", 32'(dut_rst), 32'(m_dut_rst));
`ifdef STIM_CHK_FIRST_FAIL_CAPTURE_EN
            check_output("ff_idx", 32'(ff_idx), m_ff_idx);
            check_output("ff_golden", ff_golden, m_ff_g);
            check_output("ff_dut", ff_dut, m_ff_d);
`else
            check_output("ff_idx", 32'(ff_idx), 32'd0);
            check_output("ff_golden", ff_golden, 32'd0);
            check_output("ff_dut", ff_dut, 32'd0);
`endif
        end
    end

    task automatic apply_stimulus(input int m, input string tag, input int poke_edge);
        int e;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        e = 0;
        while (!done && e < 500) begin
            @(posedge clk);
            e++;
            #1;
            start = (e == poke_edge);
            if (e == R) check_output({tag, " dut_rst_hold"}, 32'(dut_rst), 32'd1);
            if (e == R + 1) begin
                check_output({tag, " first_vec"}, stim_out, 32'h0000_0001);
                check_output({tag, " dut_rst_rel"}, 32'(dut_rst), 32'd0);
            end
            if (e == R + 1 + S) check_output({tag, " second_vec"}, stim_out, 32'h8020_0003);
        end
        start = 1'b0;
        check_output({tag, " done_edge"}, 32'(e), 32'(DONE_EDGE));
    endtask

    initial begin
        int e;
        vec[0] = 32'h1;
        for (int i = 1; i < N; i++) vec[i] = lfsr_step(vec[i-1]);
        check_output("model vec1", vec[1], 32'h8020_0003);
        check_output("model vec2", vec[2], 32'hC030_0002);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        #1;
        check_output("reset stim", stim_out, 32'd0);
        check_output("reset dut_rst", 32'(dut_rst), 32'd1);
        check_output("reset busy", 32'(busy), 32'd0);

        // Default-parameter instance in loopback: done on edge 2003.
        @(negedge clk);
        start_d = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_d = 1'b0;
        e = 0;
        while (!done_d && e < 3000) begin
            @(posedge clk);
            e++;
            #1;
        end
        check_output("def done_edge", 32'(e), 32'd2003);
        check_output("def pass", 32'(pass_d), 32'd1);
        check_output("def cnt", 32'(cnt_d), 32'd0);

        apply_stimulus(0, "loop", -1);
        check_output("loop pass", 32'(pass), 32'd1);
        check_output("loop cnt", 32'(mismatch_cnt), 32'd0);

        apply_stimulus(1, "vec5", -1);
        check_output("vec5 cnt", 32'(mismatch_cnt), 32'd1);
        check_output("vec5 pass", 32'(pass), 32'd0);
`ifdef STIM_CHK_FIRST_FAIL_CAPTURE_EN
        check_output("vec5 idx", 32'(ff_idx), 32'd5);
        check_output("vec5 diff", ff_golden ^ ff_dut, 32'd1);
        check_output("vec5 golden", ff_golden, vec[5]);
`endif

        apply_stimulus(2, "stuck", -1);
        check_output("stuck cnt", 32'(mismatch_cnt), 32'd15);
        check_output("stuck pass", 32'(pass), 32'd0);

        for (int r = 0; r < 4; r++) begin
            key = $urandom;
            apply_stimulus(3, "rand", -1);
        end

        // start while busy must be ignored: run length unchanged.
        apply_stimulus(0, "poke", 10);

        // Abort at cycle 50, then a fresh run restarts from the seed.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("abort busy", 32'(busy), 32'd0);
        check_output("abort done", 32'(done), 32'd0);
        check_output("abort dut_rst", 32'(dut_rst), 32'd1);
        check_output("abort stim", stim_out, 32'd0);
        apply_stimulus(0, "after_abort", -1);

        // start and abort together: abort wins.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_output("both busy", 32'(busy), 32'd0);
        check_output("both dut_rst", 32'(dut_rst), 32'd1);

        // Asynchronous reset mid-run with a nonzero count.
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check_output("pre_rst cnt", 32'(mismatch_cnt), 32'd5);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("arst stim", stim_out, 32'd0);
        check_output("arst dut_rst", 32'(dut_rst), 32'd1);
        check_output("arst busy", 32'(busy), 32'd0);
        check_output("arst done", 32'(done), 32'd0);
        check_output("arst pass", 32'(pass), 32'd0);
        check_output("arst cnt", 32'(mismatch_cnt), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        mode = 0;
        apply_stimulus(0, "post_rst", -1);
        check_output("post_rst pass", 32'(pass), 32'd1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
